// File: rtl/hdmi_cfg_sequencer.sv
// Walks the register table into single-byte I2C writes after reset, start or hot-plug.
// Registered outputs; each entry holds i2c_req until i2c_done, NACKs retried up to RETRY_MAX.
module hdmi_cfg_sequencer #(
  parameter int         NUM_REGS      = 31,
  parameter logic [7:0] DEV_ADDR      = 8'h72,
  parameter int         SETTLE_CYCLES = 50000,
  parameter int         RETRY_MAX     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        tx_int_n,
  output logic [5:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_val,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [5:0]    LAST_ADDR  = 6'(NUM_REGS - 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

  typedef enum logic [2:0] {IDLE, SETTLE, LOAD, ISSUE, NEXT, DONE, FAIL} state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [RW-1:0] retry;
  logic          pending;
  logic          int_s1, int_s2, int_s3;
  logic          int_ev;
  logic          run_req;

  // Synchronised falling edge of the transmitter interrupt.
  assign int_ev  = int_s3 & ~int_s2;
  assign run_req = start | int_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_s1     <= 1'b1;
      int_s2     <= 1'b1;
      int_s3     <= 1'b1;
      state      <= SETTLE;
      settle_cnt <= '0;
      retry      <= '0;
      pending    <= 1'b0;
      tbl_addr   <= '0;
      i2c_req    <= 1'b0;
      i2c_dev    <= '0;
      i2c_reg    <= '0;
      i2c_val    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      int_s1 <= tx_int_n;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
      if (state != SETTLE) pending <= pending | run_req;

      case (state)
        IDLE: begin
          if (pending) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            pending    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
          end
        end

        // Requests arriving here are served by this run; a hot-plug restarts the wait.
        SETTLE: begin
          pending <= 1'b0;
          done    <= 1'b0;
          error   <= 1'b0;
          busy    <= 1'b1;
          if (int_ev) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_END) begin
            state      <= LOAD;
            settle_cnt <= '0;
            tbl_addr   <= '0;
            retry      <= '0;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end

        LOAD: begin
          i2c_dev <= DEV_ADDR;
          i2c_reg <= tbl_data[15:8];
          i2c_val <= tbl_data[7:0];
          if (tbl_data[15:8] == 8'hFF) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= ISSUE;
            i2c_req <= 1'b1;
          end
        end

        // req low here is the one-cycle gap before a retry; done is ignored then.
        ISSUE: begin
          if (!i2c_req) begin
            i2c_req <= 1'b1;
          end else if (i2c_done) begin
            i2c_req <= 1'b0;
            if (!i2c_nack) begin
              if (tbl_addr == LAST_ADDR) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= NEXT;
              end
            end else if (retry < RETRY_LIM) begin
              retry <= retry + RW'(1);
            end else begin
              state <= FAIL;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end

        NEXT: begin
          retry    <= '0;
          tbl_addr <= tbl_addr + 6'd1;
          state    <= LOAD;
        end

        DONE, FAIL: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Randomised bench: reactive I2C slave, schedule-based reference model compared every cycle,
// plus directed scenarios with hand-computed counts and cycle numbers.
`timescale 1ns/1ps
module tb_hdmi_cfg_sequencer;
  localparam int         NR  = 4;
  localparam int         SC  = 10;
  localparam int         RM  = 3;
  localparam logic [7:0] DEV = 8'h72;

  logic        clk, reset_n, start, tx_int_n;
  logic [5:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        i2c_req;
  logic [7:0]  i2c_dev, i2c_reg, i2c_val;
  logic        i2c_done, i2c_nack;
  logic        busy, done, error;

  logic [15:0] tbl [0:63];
  assign tbl_data = tbl[tbl_addr];

  hdmi_cfg_sequencer #(.NUM_REGS(NR), .DEV_ADDR(DEV), .SETTLE_CYCLES(SC), .RETRY_MAX(RM)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tx_int_n(tx_int_n),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_val(i2c_val),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- I2C slave ----------------
  int  fixed_lat = 5;
  bit  spurious_en = 1'b0;
  int  nack_left [0:63];
  int  wait_cnt = -1;

  initial begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (!reset_n || !i2c_req) begin
      wait_cnt = -1;
      if (reset_n && spurious_en && $urandom_range(0, 7) == 0) begin
        i2c_done = 1'b1;
        i2c_nack = 1'($urandom_range(0, 1));
      end
    end else begin
      if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      if (wait_cnt == 0) begin
        i2c_done = 1'b1;
        if (nack_left[tbl_addr] > 0) begin
          i2c_nack = 1'b1;
          nack_left[tbl_addr]--;
        end
        wait_cnt = -1;
      end else begin
        wait_cnt--;
      end
    end
  end

  // ---------------- input capture at the active edge ----------------
  bit s_rstn, s_start, s_tx, s_done, s_nack;
  int rel_cyc = 0;

  always @(posedge clk) begin
    s_rstn  = reset_n;
    s_start = start;
    s_tx    = tx_int_n;
    s_done  = i2c_done;
    s_nack  = i2c_nack;
    if (reset_n) rel_cyc++;
    else rel_cyc = 0;
  end

  // ---------------- reference model (event schedule) ----------------
  bit        m_run, m_settle, m_req, m_busy, m_done, m_err, m_pend;
  int        m_cyc, m_load_at, m_rise_at, m_idle_from, m_idx, m_tries;
  logic [7:0] m_reg, m_val;
  bit        th [0:3];

  task automatic model_reset();
    m_cyc = 0; m_run = 1'b1; m_settle = 1'b1; m_load_at = SC + 1;
    m_rise_at = -1; m_idle_from = 0; m_idx = 0; m_tries = 0;
    m_req = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    m_reg = '0; m_val = '0;
    for (int i = 0; i < 4; i++) th[i] = 1'b1;
  endtask

  task automatic model_finish(input bit failed);
    m_run = 1'b0; m_busy = 1'b0; m_req = 1'b0;
    if (failed) m_err = 1'b1;
    else m_done = 1'b1;
    m_idle_from = m_cyc + 2;
  endtask

  task automatic model_load();
    m_reg = tbl[m_idx][15:8];
    m_val = tbl[m_idx][7:0];
    if (m_reg == 8'hFF) model_finish(1'b0);
    else m_req = 1'b1;
  endtask

  task automatic model_step();
    bit ev_int, ev;
    m_cyc++;
    th[3] = th[2]; th[2] = th[1]; th[1] = th[0]; th[0] = s_tx;
    ev_int = th[3] && !th[2];
    ev = s_start || ev_int;
    if (!m_run) begin
      if (m_cyc >= m_idle_from && m_pend) begin
        m_run = 1'b1; m_settle = 1'b1; m_busy = 1'b1; m_pend = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_idx = 0; m_tries = 0;
        m_load_at = m_cyc + SC + 1;
      end else begin
        m_pend = m_pend || ev;
      end
    end else if (m_settle && m_cyc < m_load_at) begin
      m_busy = 1'b1; m_pend = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (ev_int) m_load_at = m_cyc + SC + 1;
    end else begin
      m_settle = 1'b0;
      m_pend = m_pend || ev;
      if (m_cyc == m_load_at) model_load();
      else if (m_cyc == m_rise_at) m_req = 1'b1;
      else if (m_req && s_done) begin
        m_req = 1'b0;
        if (!s_nack) begin
          if (m_idx == NR - 1) model_finish(1'b0);
          else begin
            m_idx++; m_tries = 0; m_load_at = m_cyc + 2;
          end
        end else if (m_tries < RM) begin
          m_tries++; m_rise_at = m_cyc + 1;
        end else begin
          model_finish(1'b1);
        end
      end
    end
  endtask

  // ---------------- compare + monitor ----------------
  int n_req = 0, n_req_e1 = 0, n_end = 0, n_runs = 0;
  int first_rise = -1, end_cyc = -1;
  bit p_req = 1'b0, p_end = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) model_reset();
    else if (s_rstn) model_step();

    chk("busy",  32'(busy),    32'(m_busy));
    chk("done",  32'(done),    32'(m_done));
    chk("error", 32'(error),   32'(m_err));
    chk("req",   32'(i2c_req), 32'(m_req));
    if (m_req) begin
      chk("dev",      32'(i2c_dev),  32'(DEV));
      chk("reg",      32'(i2c_reg),  32'(m_reg));
      chk("val",      32'(i2c_val),  32'(m_val));
      chk("tbl_addr", 32'(tbl_addr), 32'(m_idx));
    end

    if (!reset_n) first_rise = -1;
    if (i2c_req && !p_req) begin
      n_req++;
      if (tbl_addr == 6'd1) n_req_e1++;
      if (first_rise < 0) first_rise = rel_cyc;
    end
    if ((done || error) && !p_end) begin
      n_end++;
      end_cyc = rel_cyc;
    end
    if (busy && !p_busy) n_runs++;
    p_req  = i2c_req;
    p_end  = done || error;
    p_busy = busy;
  end

  // ---------------- scenarios ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int count, input int limit);
    int target = n_end + count;
    int k = 0;
    while (n_end < target && k < limit) begin
      @(posedge clk); #2;
      k++;
    end
    chk({name, "_finished"}, 32'(n_end >= target), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, base_e1, base_end, base_runs, k;
    start = 1'b0;
    tx_int_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tbl[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      nack_left[i] = 0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req",  32'(i2c_req), 32'd0);
    chk("reset_addr", 32'(tbl_addr), 32'd0);

    // 1: automatic run after reset, fixed 5-cycle ack latency
    base = n_req;
    reset_n = 1'b1;
    wait_end("s1", 1, 300);
    chk("s1_first_req_cycle", 32'(first_rise), 32'd11);
    chk("s1_done_cycle",      32'(end_cyc),    32'd41);
    chk("s1_writes",          32'(n_req - base), 32'd4);
    chk("s1_done",  32'(done),  32'd1);
    chk("s1_error", 32'(error), 32'd0);

    fixed_lat = -1;
    spurious_en = 1'b1;

    // 2: terminator at entry 2
    tbl[2][15:8] = 8'hFF;
    base = n_req;
    pulse_start();
    wait_end("s2", 1, 300);
    chk("s2_writes", 32'(n_req - base), 32'd2);
    chk("s2_done",   32'(done), 32'd1);
    tbl[2][15:8] = 8'h3C;

    // 3: entry 1 NACKed twice then acked
    nack_left[1] = 2;
    base = n_req;
    pulse_start();
    wait_end("s3", 1, 300);
    chk("s3_writes", 32'(n_req - base), 32'd6);
    chk("s3_done",   32'(done), 32'd1);
    chk("s3_error",  32'(error), 32'd0);

    // 4: entry 0 NACKed past the retry limit
    nack_left[0] = 4;
    base = n_req;
    base_e1 = n_req_e1;
    pulse_start();
    wait_end("s4", 1, 300);
    chk("s4_writes",  32'(n_req - base), 32'd4);
    chk("s4_e1_reqs", 32'(n_req_e1 - base_e1), 32'd0);
    chk("s4_error", 32'(error), 32'd1);
    chk("s4_done",  32'(done),  32'd0);
    chk("s4_busy",  32'(busy),  32'd0);

    // 5: interrupt mid-run plus start coincident with a later ack -> exactly one more run
    base = n_req;
    base_end = n_end;
    base_runs = n_runs;
    pulse_start();
    k = 0;
    while (n_req - base < 2 && k < 300) begin @(posedge clk); #2; k++; end
    tx_int_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 tx_int_n = 1'b1;
    k = 0;
    while (!(i2c_done && i2c_req) && k < 300) begin @(posedge clk); #2; k++; end
    pulse_start();
    wait_end("s5", 2 - (n_end - base_end), 600);
    repeat (60) @(posedge clk);
    #2;
    chk("s5_runs_ended",   32'(n_end - base_end),   32'd2);
    chk("s5_runs_started", 32'(n_runs - base_runs), 32'd2);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_done", 32'(done), 32'd1);

    // 6: reset while a request is outstanding, then full rerun from entry 0
    pulse_start();
    k = 0;
    while (!(i2c_req && tbl_addr >= 6'd1) && k < 300) begin @(posedge clk); #2; k++; end
    reset_n = 1'b0;
    #1;
    chk("s6_req_async",  32'(i2c_req),  32'd0);
    chk("s6_busy_async", 32'(busy),     32'd0);
    chk("s6_addr_async", 32'(tbl_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    base = n_req;
    reset_n = 1'b1;
    wait_end("s6", 1, 300);
    chk("s6_first_req_cycle", 32'(first_rise), 32'd11);
    chk("s6_writes", 32'(n_req - base), 32'd4);
    chk("s6_done",   32'(done), 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
